// File: rtl/ysyx_22040088_wbu.sv
// ----------------------------------------------------------------------------
// ysyx_22040088_wbu : writeback unit
//
// This unit drives the single GPR write port. It accepts completed results
// from the EXU (ALU/CSR results) and from the LSU (load data) over
// valid/ready handshakes. At most one result is accepted per cycle. Load data
// is shifted and sign/zero extended here, and writes to x0 are suppressed.
// The resulting write is registered for one cycle.
//
// Parameters
//   STARVE_MAX   number of consecutive cycles the EXU may lose arbitration
//                to the LSU before the EXU is given priority
//
// Ports
//   clk, rst_n                  core clock, asynchronous active-low reset
//   exu_valid/exu_ready         EXU result handshake
//   exu_rd/exu_wen/exu_data     EXU destination, write flag, result value
//   lsu_valid/lsu_ready         LSU load handshake
//   lsu_rd/lsu_funct3           load destination and load type
//   lsu_addr_lo/lsu_rdata       byte offset within the doubleword, raw doubleword
//   rf_wen/rf_waddr/rf_wdata    registered GPR write port
//   fwd_valid/fwd_rd/fwd_data   copy of the in-flight write for bypassing
//   misalign                    one-cycle pulse: accepted load was dropped
//   retire_cnt                  count of accepted results (wraps)
// ----------------------------------------------------------------------------
module ysyx_22040088_wbu #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        exu_valid,
    output logic        exu_ready,
    input  logic [4:0]  exu_rd,
    input  logic        exu_wen,
    input  logic [63:0] exu_data,

    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [2:0]  lsu_funct3,
    input  logic [2:0]  lsu_addr_lo,
    input  logic [63:0] lsu_rdata,

    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,

    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [63:0] fwd_data,

    output logic        misalign,
    output logic [63:0] retire_cnt
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    // Load formatting: pick the addressed bytes and extend to 64 bits.
    // funct3 = 111 has no defined format; it is rejected by load_bad().
    function automatic logic [63:0] load_fmt(input logic [63:0] sh,
                                             input logic [2:0]  funct3);
        logic signed [7:0]  sb;
        logic signed [15:0] shw;
        logic signed [31:0] sw;
        logic [63:0]        res;
        sb  = signed'(sh[7:0]);
        shw = signed'(sh[15:0]);
        sw  = signed'(sh[31:0]);
        case (funct3)
            3'b000:  res = 64'(sb);
            3'b001:  res = 64'(shw);
            3'b010:  res = 64'(sw);
            3'b011:  res = sh;
            3'b100:  res = {56'd0, sh[7:0]};
            3'b101:  res = {48'd0, sh[15:0]};
            3'b110:  res = {32'd0, sh[31:0]};
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    // A load whose write must be dropped: misaligned halfword/word/doubleword
    // access, or the unused funct3 encoding.
    function automatic logic load_bad(input logic [2:0] funct3,
                                      input logic [2:0] addr_lo);
        logic bad;
        case (funct3)
            3'b001, 3'b101: bad = addr_lo[0];
            3'b010, 3'b110: bad = (addr_lo[1:0] != 2'b00);
            3'b011:         bad = (addr_lo != 3'b000);
            3'b111:         bad = 1'b1;
            default:        bad = 1'b0;
        endcase
        return bad;
    endfunction

    logic [SW-1:0] starve_cnt;
    logic          starve;
    logic          both_valid;
    logic          exu_fire;
    logic          lsu_fire;
    logic [63:0]   lsu_sh;
    logic [63:0]   lsu_fmt;
    logic          lsu_drop;

    // Arbitration. Ready depends only on valids, the starvation state and
    // reset, never on the payload. The losing source is the only one ever
    // held off, so a source that is not competing sees ready=1.
    assign starve     = (starve_cnt == SW'(STARVE_MAX));
    assign both_valid = exu_valid & lsu_valid;
    assign exu_ready  = rst_n & ~(both_valid & ~starve);
    assign lsu_ready  = rst_n & ~(both_valid & starve);
    assign exu_fire   = exu_valid & exu_ready;
    assign lsu_fire   = lsu_valid & lsu_ready;

    assign lsu_sh   = lsu_rdata >> {lsu_addr_lo, 3'b000};
    assign lsu_fmt  = load_fmt(lsu_sh, lsu_funct3);
    assign lsu_drop = load_bad(lsu_funct3, lsu_addr_lo);

    // ---- accept -> registered write port ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            rf_wen     <= 1'b0;
            rf_waddr   <= 5'd0;
            rf_wdata   <= 64'd0;
            misalign   <= 1'b0;
            retire_cnt <= 64'd0;
        end else begin
            // Counts consecutive cycles the EXU lost to the LSU; saturates
            // because the starve state then guarantees the next EXU win.
            if (exu_fire)
                starve_cnt <= '0;
            else if (both_valid && !starve)
                starve_cnt <= starve_cnt + SW'(1);

            rf_wen   <= 1'b0;
            misalign <= 1'b0;

            if (exu_fire) begin
                rf_wen   <= exu_wen & (exu_rd != 5'd0);
                rf_waddr <= exu_rd;
                rf_wdata <= exu_data;
            end else if (lsu_fire) begin
                rf_wen   <= ~lsu_drop & (lsu_rd != 5'd0);
                misalign <= lsu_drop;
                rf_waddr <= lsu_rd;
                rf_wdata <= lsu_fmt;
            end

            if (exu_fire || lsu_fire)
                retire_cnt <= retire_cnt + 64'd1;
        end
    end

    // The regfile commits at the next edge; readers in this cycle bypass.
    assign fwd_valid = rf_wen;
    assign fwd_rd    = rf_waddr;
    assign fwd_data  = rf_wdata;

endmodule

// File: tb/tb_ysyx_22040088_wbu.sv
module tb_ysyx_22040088_wbu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exu_valid, exu_ready, exu_wen;
    logic [4:0]  exu_rd;
    logic [63:0] exu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [2:0]  lsu_funct3, lsu_addr_lo;
    logic [63:0] lsu_rdata;
    logic        rf_wen, fwd_valid, misalign;
    logic [4:0]  rf_waddr, fwd_rd;
    logic [63:0] rf_wdata, fwd_data, retire_cnt;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_retire = 64'd0;

    ysyx_22040088_wbu #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd),
        .exu_wen(exu_wen), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
        .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo), .lsu_rdata(lsu_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .misalign(misalign), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_lsu;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] data;     // exu_data or lsu_rdata
        logic [2:0]  funct3;
        logic [2:0]  addr_lo;
        logic        exp_wen;
        logic        exp_mis;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit l, logic [4:0] rd, logic wen, logic [63:0] d,
                                logic [2:0] f3, logic [2:0] lo,
                                logic ew, logic em, logic [63:0] ed);
        vec_t v;
        v.is_lsu = l; v.rd = rd; v.wen = wen; v.data = d; v.funct3 = f3;
        v.addr_lo = lo; v.exp_wen = ew; v.exp_mis = em; v.exp_data = ed;
        return v;
    endfunction

    task automatic idle_inputs();
        exu_valid = 0; exu_rd = 0; exu_wen = 0; exu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_funct3 = 0; lsu_addr_lo = 0; lsu_rdata = 0;
    endtask

    initial begin
        string winners;
        vecs[0]  = mk(0, 5'd5,  1, 64'h1234,                3'b000, 3'd0, 1, 0, 64'h1234);
        vecs[1]  = mk(1, 5'd7,  0, 64'h0000_0000_8000_0000, 3'b000, 3'd3, 1, 0, 64'hFFFF_FFFF_FFFF_FF80);
        vecs[2]  = mk(1, 5'd7,  0, 64'h0000_0000_8000_0000, 3'b100, 3'd3, 1, 0, 64'h80);
        vecs[3]  = mk(1, 5'd8,  0, 64'h8765_4321_0000_0000, 3'b010, 3'd4, 1, 0, 64'hFFFF_FFFF_8765_4321);
        vecs[4]  = mk(1, 5'd9,  0, 64'h1111_2222_3333_4444, 3'b001, 3'd1, 0, 1, 64'h0);
        vecs[5]  = mk(0, 5'd0,  1, 64'hDEAD,                3'b000, 3'd0, 0, 0, 64'hDEAD);
        vecs[6]  = mk(1, 5'd1,  0, 64'h0123_4567_89AB_CDEF, 3'b011, 3'd0, 1, 0, 64'h0123_4567_89AB_CDEF);
        vecs[7]  = mk(1, 5'd2,  0, 64'hFEDC_0000_0000_0000, 3'b001, 3'd6, 1, 0, 64'hFFFF_FFFF_FFFF_FEDC);
        vecs[8]  = mk(1, 5'd3,  0, 64'h55,                  3'b111, 3'd0, 0, 1, 64'h0);
        vecs[9]  = mk(1, 5'd4,  0, 64'h8765_4321_0000_0000, 3'b110, 3'd4, 1, 0, 64'h8765_4321);
        vecs[10] = mk(0, 5'd3,  0, 64'hBEEF,                3'b000, 3'd0, 0, 0, 64'hBEEF);
        vecs[11] = mk(1, 5'd6,  0, 64'h77,                  3'b011, 3'd4, 0, 1, 64'h0);
        vecs[12] = mk(1, 5'd0,  0, 64'h0000_0000_0000_007F, 3'b000, 3'd0, 0, 0, 64'h7F);

        // Reset state
        idle_inputs();
        rst_n = 0;
        #12;
        chk("reset_rf_wen", rf_wen, 0);
        chk("reset_waddr", rf_waddr, 0);
        chk("reset_wdata", rf_wdata, 0);
        chk("reset_misalign", misalign, 0);
        chk("reset_retire", retire_cnt, 0);
        chk("reset_exu_ready", exu_ready, 0);
        chk("reset_lsu_ready", lsu_ready, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        chk("idle_exu_ready", exu_ready, 1);
        chk("idle_lsu_ready", lsu_ready, 1);

        // Table-driven single-source transfers
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_lsu) begin
                lsu_valid = 1; lsu_rd = vecs[i].rd; lsu_funct3 = vecs[i].funct3;
                lsu_addr_lo = vecs[i].addr_lo; lsu_rdata = vecs[i].data;
            end else begin
                exu_valid = 1; exu_rd = vecs[i].rd; exu_wen = vecs[i].wen;
                exu_data = vecs[i].data;
            end
            #1;
            chk($sformatf("v%0d_ready", i), vecs[i].is_lsu ? lsu_ready : exu_ready, 1);
            @(posedge clk); #1;
            exp_retire++;
            chk($sformatf("v%0d_rf_wen", i), rf_wen, vecs[i].exp_wen);
            chk($sformatf("v%0d_fwd_valid", i), fwd_valid, vecs[i].exp_wen);
            chk($sformatf("v%0d_misalign", i), misalign, vecs[i].exp_mis);
            chk($sformatf("v%0d_retire", i), retire_cnt, exp_retire);
            if (!vecs[i].exp_mis) begin
                chk($sformatf("v%0d_waddr", i), rf_waddr, 64'(vecs[i].rd));
                chk($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].exp_data);
                chk($sformatf("v%0d_fwd_rd", i), fwd_rd, 64'(vecs[i].rd));
                chk($sformatf("v%0d_fwd_data", i), fwd_data, vecs[i].exp_data);
            end
            idle_inputs();
            @(posedge clk); #1;
            chk($sformatf("v%0d_idle_wen", i), rf_wen, 0);
            chk($sformatf("v%0d_idle_mis", i), misalign, 0);
            chk($sformatf("v%0d_idle_retire", i), retire_cnt, exp_retire);
            if (!vecs[i].exp_mis)
                chk($sformatf("v%0d_hold_wdata", i), rf_wdata, vecs[i].exp_data);
        end

        // Both sources valid continuously: LLLL E LLLL
        winners = "LLLLELLLL";
        exu_valid = 1; exu_rd = 5'd9; exu_wen = 1; exu_data = 64'hAAAA;
        lsu_valid = 1; lsu_rd = 5'd10; lsu_funct3 = 3'b011; lsu_addr_lo = 0;
        lsu_rdata = 64'h5555;
        for (int c = 0; c < 9; c++) begin
            bit lw;
            lw = (winners[c] == "L");
            #1;
            chk($sformatf("arb%0d_exu_ready", c), exu_ready, !lw);
            chk($sformatf("arb%0d_lsu_ready", c), lsu_ready, lw);
            @(posedge clk); #1;
            exp_retire++;
            chk($sformatf("arb%0d_waddr", c), rf_waddr, lw ? 64'd10 : 64'd9);
            chk($sformatf("arb%0d_wdata", c), rf_wdata, lw ? 64'h5555 : 64'hAAAA);
            chk($sformatf("arb%0d_retire", c), retire_cnt, exp_retire);
        end
        idle_inputs();
        @(posedge clk); #1;

        // Reset dropped mid-stream while a write is in flight
        exu_valid = 1; exu_rd = 5'd4; exu_wen = 1; exu_data = 64'h77;
        @(posedge clk); #1;
        chk("pre_rst_wen", rf_wen, 1);
        #2; rst_n = 0; #1;
        chk("async_rst_wen", rf_wen, 0);
        chk("async_rst_retire", retire_cnt, 0);
        chk("async_rst_exu_ready", exu_ready, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        chk("post_rst_wen", rf_wen, 1);
        chk("post_rst_waddr", rf_waddr, 4);
        chk("post_rst_wdata", rf_wdata, 64'h77);
        chk("post_rst_retire", retire_cnt, 1);
        idle_inputs();
        @(posedge clk); #1;
        chk("post_rst_idle_wen", rf_wen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
